fc_layer_engine: RTL
====================

# fc_layer_engine

Runtime-configurable fully-connected layer engine for the LeNet accelerator. It is the parametrised successor of the fixed FC1/FC2 datapath. A per-run configuration sets input length, output count, weight base address, requantisation shift and optional ReLU. It streams NUM_BANK activation SRAM banks against one weight SRAM word per cycle, accumulates signed dot products, and writes saturated int8 results byte-wise, round-robin, into NUM_BANK output banks.

## Interface
Parameters:
- DATA_WIDTH, 8, activation/result width (signed)
- DATA_PER_WORD, 4, activations per 32-bit SRAM word
- NUM_BANK, 5, activation input banks = output banks
- WEIGHT_WIDTH, 4, signed weight width
- WEIGHT_NUM, 20, weights per weight-SRAM word; must equal NUM_BANK*DATA_PER_WORD
- WEIGHT_ADDR_WIDTH, 15, weight address width
- ACC_WIDTH, 28, accumulator width

Ports:
- clk  in  1  clock, rising edge
- srstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle run request, ignored while busy
- cfg_in_words  in  10  activation words per output neuron
- cfg_out_num  in  10  output neurons
- cfg_weight_base  in  WEIGHT_ADDR_WIDTH  first weight address
- cfg_shift  in  4  arithmetic right shift for requantisation
- cfg_relu  in  1  clamp negatives to 0
- act_raddr  out  10  read address, shared by all input banks
- act_rdata  in  NUM_BANK*32  bank 0 in MSBs; byte 0 of each word at [31:24]
- w_raddr  out  WEIGHT_ADDR_WIDTH  weight read address
- w_rdata  in  WEIGHT_NUM*WEIGHT_WIDTH  weight j at [(WEIGHT_NUM-1-j)*WEIGHT_WIDTH +: WEIGHT_WIDTH]
- out_wsb  out  NUM_BANK  per-bank write strobe, active-low
- out_bytemask  out  4  active-low byte enable; lane 0 = [31:24]
- out_waddr  out  10  output write address
- out_wdata  out  8  result byte
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse

## Operation
- The config is latched when start is accepted in IDLE.
- Element index j = bank*DATA_PER_WORD + byte. Each cycle adds sum over j of act[j]*w[j]: products are 12-bit signed, and the 20-term sum is 17-bit.
- Address sequence: for o in 0..out_num-1, for k in 0..in_words-1, act_raddr = k. w_raddr starts at cfg_weight_base and increments by 1 every issue cycle, with no gaps between neurons.
- The pipeline carries first/last tags. On a first term the accumulator loads; on other terms it adds. ACC_WIDTH wraps, with no overflow detection.
- Requantisation of the final accumulator:
  - If shift>0, add 1<<(shift-1), then shift arithmetically right by cfg_shift.
  - If relu is set, clamp negatives to 0.
  - Saturate to [-128,127].
- Neuron n maps to word w = n/4 and lane n%4. The word goes to bank w%NUM_BANK at address w/NUM_BANK. Only that bank's wsb is 0, and out_bytemask has 0 only in lane n%4 (lane 0 = 4'b0111).
- FSM:
  - IDLE→RUN on start when in_words≠0 and out_num≠0.
  - IDLE→DONE on start when either is zero; no writes occur.
  - RUN→DRAIN after the last address issue.
  - DRAIN→DONE after the last write.
  - DONE→IDLE.
- busy is high in RUN, DRAIN and DONE. done is high only in DONE.
- Reset values: act_raddr 0, w_raddr 0, out_wsb all 1, out_bytemask 4'hF, out_waddr 0, out_wdata 0, busy 0, done 0, FSM IDLE, pipeline tags cleared.
- Reset mid-run aborts immediately. No further writes occur, and the next start behaves as from a clean state.

## Timing
- c0 is the cycle start is high.
- Addresses for (o=0,k=0) are driven in c1; SRAM data returns in c2, products are registered in c3, and the accumulator updates in c4.
- With N = out_num*in_words, issue runs c1..cN. The write for the neuron whose last term issued in cL is driven in cL+4, so the final write is in cN+4 and done is in cN+5.
- Zero config: done in c1.
- Throughput is one activation word per cycle with no stall.

## Structure
- fc_pkg holds the DATA_WIDTH/DATA_PER_WORD constants, the state enum {IDLE, RUN, DRAIN, DONE} and the requant/saturate function.
- Sub-module fc_dot_unit contains the WEIGHT_NUM signed multipliers and a registered adder tree, c2→c3 (product and sum registered).
- The top holds the FSM, counters, accumulator, requant and write mapping.

## Test plan
- LeNet FC1 (in_words=40, out_num=500, base=0, relu=1) with pool2 data in the input banks → all 125 output words match golden; done at c20005.
- FC2 (in_words=25, out_num=10, base=20000, relu=0) → bytes 0..9 match golden; lanes 2..3 of bank 2 address 0 keep their prior contents.
- Saturation, with in_words=1, out_num=1, shift=0:
  - All activations 127 and weights 7 → sum 17780 → writes 127.
  - Weights -8 → -128.
  - relu=1 → 0.
  - First write in c5, done in c6.
- Rounding: sum 6 with shift=2 → 2; sum -6 with shift=2 → -1; sum 5 with shift=1 → 3.
- Bank routing: out_num=24, in_words=1 → words 0..5 go to banks 0,1,2,3,4,0 at addresses 0,0,0,0,0,1; out_num=0 → done in c1 and no wsb activity.
- start pulsed in c50 of a run is ignored. srstn low at c100 puts outputs at reset values within the same cycle. A fresh start after release reproduces the golden results.

Source files
------------

// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, FSM encodings and the
// requantise/saturate helper for the FC layer engine.
package fc_pkg;

  localparam int FC_DATA_WIDTH    = 8;
  localparam int FC_DATA_PER_WORD = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Round half up, arithmetic shift, optional ReLU, clamp to int8.
  function automatic logic [7:0] requant(
    input logic signed [63:0] acc,
    input logic [3:0]         shift,
    input logic               relu
  );
    logic signed [63:0] v;
    v = acc;
    if (shift != 4'd0)
      v = v + (64'sd1 <<< (shift - 4'd1));
    v = v >>> shift;
    if (relu && v < 0)
      v = '0;
    if (v > 64'sd127)
      return 8'h7F;
    if (v < -64'sd128)
      return 8'h80;
    return v[7:0];
  endfunction

endpackage

// File: rtl/fc_dot_unit.sv
// fc_dot_unit: signed activation x weight products
// summed and registered one cycle after SRAM data.
module fc_dot_unit
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH    = FC_DATA_WIDTH,
  parameter int DATA_PER_WORD = FC_DATA_PER_WORD,
  parameter int NUM_BANK      = 5,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int WEIGHT_NUM    = 20,
  parameter int SUM_WIDTH     = 17
) (
  input  logic clk,
  input  logic srstn,
  input  logic [NUM_BANK*DATA_PER_WORD*DATA_WIDTH-1:0] act,
  input  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] wgt,
  output logic signed [SUM_WIDTH-1:0] sum
);

  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int WW = DATA_PER_WORD * DATA_WIDTH;

  logic signed [DATA_WIDTH-1:0]   a;
  logic signed [WEIGHT_WIDTH-1:0] w;
  logic signed [PW-1:0]           p;
  logic signed [SUM_WIDTH-1:0]    tree;

  // Element j = bank*DATA_PER_WORD + byte, bank 0 and byte 0 in MSBs.
  always_comb begin
    a = '0;
    w = '0;
    p = '0;
    tree = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int y = 0; y < DATA_PER_WORD; y++) begin
        a = act[(NUM_BANK-1-b)*WW
                + (DATA_PER_WORD-1-y)*DATA_WIDTH
                +: DATA_WIDTH];
        w = wgt[(WEIGHT_NUM-1-(b*DATA_PER_WORD+y))
                * WEIGHT_WIDTH +: WEIGHT_WIDTH];
        p = PW'(a) * PW'(w);
        tree = tree + SUM_WIDTH'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)
      sum <= '0;
    else
      sum <= tree;
  end

endmodule

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: runtime-configured fully-connected layer,
// one activation word per cycle, int8 results byte-wise to banks.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH        = FC_DATA_WIDTH,
  parameter int DATA_PER_WORD     = FC_DATA_PER_WORD,
  parameter int NUM_BANK          = 5,
  parameter int WEIGHT_WIDTH      = 4,
  parameter int WEIGHT_NUM        = 20,
  parameter int WEIGHT_ADDR_WIDTH = 15,
  parameter int ACC_WIDTH         = 28
) (
  input  logic                               clk,
  input  logic                               srstn,
  input  logic                               start,
  input  logic [9:0]                         cfg_in_words,
  input  logic [9:0]                         cfg_out_num,
  input  logic [WEIGHT_ADDR_WIDTH-1:0]       cfg_weight_base,
  input  logic [3:0]                         cfg_shift,
  input  logic                               cfg_relu,
  output logic [9:0]                         act_raddr,
  input  logic [NUM_BANK*32-1:0]             act_rdata,
  output logic [WEIGHT_ADDR_WIDTH-1:0]       w_raddr,
  input  logic [WEIGHT_NUM*WEIGHT_WIDTH-1:0] w_rdata,
  output logic [NUM_BANK-1:0]                out_wsb,
  output logic [3:0]                         out_bytemask,
  output logic [9:0]                         out_waddr,
  output logic [7:0]                         out_wdata,
  output logic                               busy,
  output logic                               done
);

  localparam int SUM_WIDTH =
    DATA_WIDTH + WEIGHT_WIDTH + $clog2(WEIGHT_NUM);
  localparam int BW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

  logic [1:0] state;
  logic [9:0] words, num, o_cnt;
  logic [3:0] shift;
  logic       relu;
  logic       v0, f0, l0, v1, f1, l1, v2, f2, l2, fin;
  logic signed [SUM_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [9:0]    n_cnt, wword;
  logic [1:0]    lane;
  logic [BW-1:0] bank;
  logic          wr_last, accept, last_k, last_o, zero;

  assign accept = start && (state == IDLE);
  assign last_k = act_raddr == words - 10'd1;
  assign last_o = o_cnt == num - 10'd1;
  assign zero   = (cfg_in_words == 10'd0) || (cfg_out_num == 10'd0);
  assign busy   = state != IDLE;
  assign done   = state == DONE;

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state     <= IDLE;
      words     <= '0;
      num       <= '0;
      shift     <= '0;
      relu      <= 1'b0;
      o_cnt     <= '0;
      act_raddr <= '0;
      w_raddr   <= '0;
      v0        <= 1'b0;
      f0        <= 1'b0;
      l0        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          words     <= cfg_in_words;
          num       <= cfg_out_num;
          shift     <= cfg_shift;
          relu      <= cfg_relu;
          o_cnt     <= '0;
          act_raddr <= '0;
          w_raddr   <= cfg_weight_base;
          if (zero) begin
            state <= DONE;
          end else begin
            state <= RUN;
            v0    <= 1'b1;
            f0    <= 1'b1;
            l0    <= cfg_in_words == 10'd1;
          end
        end
        RUN: if (last_k && last_o) begin
          state <= DRAIN;
          v0    <= 1'b0;
        end else begin
          w_raddr <= w_raddr + WEIGHT_ADDR_WIDTH'(1);
          if (last_k) begin
            act_raddr <= '0;
            o_cnt     <= o_cnt + 10'd1;
            f0        <= 1'b1;
            l0        <= words == 10'd1;
          end else begin
            act_raddr <= act_raddr + 10'd1;
            f0        <= 1'b0;
            l0        <= act_raddr + 10'd2 == words;
          end
        end
        DRAIN: if (wr_last) state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fc_dot_unit #(
    .DATA_WIDTH   (DATA_WIDTH),
    .DATA_PER_WORD(DATA_PER_WORD),
    .NUM_BANK     (NUM_BANK),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .WEIGHT_NUM   (WEIGHT_NUM),
    .SUM_WIDTH    (SUM_WIDTH)
  ) u_dot (
    .clk  (clk),
    .srstn(srstn),
    .act  (act_rdata),
    .wgt  (w_rdata),
    .sum  (sum)
  );

  // Tags follow the address through SRAM read and product stages.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      {v1, f1, l1, v2, f2, l2, fin} <= '0;
      acc <= '0;
    end else begin
      {v1, f1, l1} <= {v0, f0, l0};
      {v2, f2, l2} <= {v1, f1, l1};
      fin          <= v2 && l2;
      if (v2)
        acc <= f2 ? ACC_WIDTH'(sum) : acc + ACC_WIDTH'(sum);
    end
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      out_wsb      <= '1;
      out_bytemask <= 4'hF;
      out_waddr    <= '0;
      out_wdata    <= '0;
      wr_last      <= 1'b0;
      n_cnt        <= '0;
      wword        <= '0;
      lane         <= '0;
      bank         <= '0;
    end else begin
      out_wsb      <= '1;
      out_bytemask <= 4'hF;
      wr_last      <= 1'b0;
      if (accept) begin
        n_cnt <= '0;
        wword <= '0;
        lane  <= '0;
        bank  <= '0;
      end else if (fin) begin
        out_wsb      <= ~(NUM_BANK'(1) << bank);
        out_bytemask <= ~(4'b1000 >> lane);
        out_waddr    <= wword;
        out_wdata    <= requant(64'(acc), shift, relu);
        wr_last      <= n_cnt == num - 10'd1;
        n_cnt        <= n_cnt + 10'd1;
        lane         <= lane + 2'd1;
        if (lane == 2'd3) begin
          if (bank == BW'(NUM_BANK - 1)) begin
            bank  <= '0;
            wword <= wword + 10'd1;
          end else begin
            bank <= bank + BW'(1);
          end
        end
      end
    end
  end

endmodule
